// File: rtl/rvvLitePkg.sv
// Shared vector-lite types: ALU response beat, register-file write beat, writeback modes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rvvLitePkg;

  localparam int DATA_WIDTH     = 64;
  localparam int REGISTER_COUNT = 32;
  localparam int ADDR_WIDTH     = 12;
  localparam int REG_W          = $clog2(REGISTER_COUNT);
  localparam int OFF_W          = ADDR_WIDTH - REG_W;
  localparam int BE_W           = DATA_WIDTH / 8;
  localparam int MASK_PTR_W     = $clog2(DATA_WIDTH);
  localparam int NARROW_HALF    = DATA_WIDTH / 2;

  typedef enum logic [1:0] {
    WB_PASS,
    WB_NARROW,
    WB_MASK,
    WB_SCALAR
  } wb_mode_t;

  typedef struct packed {
    logic                  valid;
    logic                  start_flag;
    logic                  end_flag;
    logic                  whole_reg;
    logic                  mask;
    logic                  narrow;
    logic                  scalar;
    logic [1:0]            sew;
    logic [REG_W-1:0]      addr;
    logic [OFF_W-1:0]      off;
    logic [DATA_WIDTH-1:0] data;
    logic [BE_W-1:0]       be;
  } valu_resp_t;

  typedef struct packed {
    logic                  valid;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic [BE_W-1:0]       be;
    logic                  start_flag;
    logic                  end_flag;
  } dstream_t;

endpackage

// File: rtl/valu_mask_accum.sv
// Mask-bit accumulator: appends 8>>sew bits per beat into a word at bit pointer mptr.
// Latency: word/be/emit are a combinational view of the current beat; mptr and partial word registered.
// Backpressure: none internally; the caller asserts insert only on an accepted beat.
module valu_mask_accum
  import rvvLitePkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  insert,
  input  logic                  end_flag,
  input  logic [1:0]            sew,
  input  logic [7:0]            bits,
  output logic                  emit,
  output logic [DATA_WIDTH-1:0] word,
  output logic [BE_W-1:0]       be,
  output logic                  pending
);

  localparam int PW = MASK_PTR_W;

  logic [PW-1:0]         mptr_q;
  logic [DATA_WIDTH-1:0] acc_q;
  logic [PW:0]           base_ptr;
  logic [PW:0]           total;
  logic [PW:0]           nbytes;
  logic [3:0]            n;
  logic [7:0]            lane_bits;
  logic [DATA_WIDTH-1:0] base_word;
  logic [DATA_WIDTH-1:0] ins;
  logic                  full;

  // Insert this beat's bits at the pointer; a start beat begins from an empty word.
  always_comb begin
    n         = 4'd8 >> sew;
    base_ptr  = clear ? '0 : {1'b0, mptr_q};
    base_word = clear ? '0 : acc_q;
    for (int j = 0; j < 8; j++) begin
      lane_bits[j] = bits[j] & (4'(j) < n);
    end
    ins    = {{(DATA_WIDTH-8){1'b0}}, lane_bits} << base_ptr;
    total  = base_ptr + {{(PW-3){1'b0}}, n};
    nbytes = (total + (PW+1)'(7)) >> 3;
    full   = (total >= (PW+1)'(DATA_WIDTH));
    word   = base_word | ins;
    emit   = insert & (full | end_flag);
    for (int i = 0; i < BE_W; i++) begin
      be[i] = full | (nbytes > (PW+1)'(i));
    end
    pending = (mptr_q != '0);
  end

  // Keep the partial word until it fills or the instruction ends; a new start discards it.
  always_ff @(posedge clk) begin
    if (rst) begin
      mptr_q <= '0;
      acc_q  <= '0;
    end else if (insert) begin
      if (emit) begin
        mptr_q <= '0;
        acc_q  <= '0;
      end else begin
        mptr_q <= total[PW-1:0];
        acc_q  <= word;
      end
    end else if (clear) begin
      mptr_q <= '0;
      acc_q  <= '0;
    end
  end

endmodule

// File: rtl/valu_wb_packer.sv
// Packs vALU response beats (pass/narrow/mask) into register-file write beats; scalars go to sca_*.
// Latency: one cycle from the beat completing a word to wb.valid; sca_valid one cycle after acceptance.
// Backpressure: resp_ready = !wb.valid | wb_ready, no skid buffer; wb held stable while stalled.
module valu_wb_packer
  import rvvLitePkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = rvvLitePkg::ADDR_WIDTH,
  parameter int OFF_W      = ADDR_WIDTH - $clog2(rvvLitePkg::REGISTER_COUNT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  valu_resp_t            resp,
  output logic                  resp_ready,
  output dstream_t              wb,
  input  logic                  wb_ready,
  output logic                  sca_valid,
  output logic [DATA_WIDTH-1:0] sca_data,
  output logic                  err
);

  localparam int HB = BE_W / 2;

  wb_mode_t              mode_q, mode_d, start_mode, beat_mode;
  logic                  open_q, open_d;
  logic                  half_q, half_d;
  logic                  first_q, first_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, base_ptr, beat_addr;
  logic [OFF_W-1:0]      beat_off;
  logic [NARROW_HALF-1:0] lo_dat_q, lo_dat_d;
  logic [HB-1:0]         lo_be_q, lo_be_d;
  logic                  accept, start_acc, live, cur_half, cur_first;
  logic                  emit, sca_d, err_d;
  dstream_t              emit_beat;
  logic                  m_insert, m_emit, m_pending;
  logic [DATA_WIDTH-1:0] m_word;
  logic [BE_W-1:0]       m_be;

  assign resp_ready = !wb.valid | wb_ready;
  assign beat_off   = resp.off;
  assign beat_addr  = {resp.addr, beat_off};

  // Acceptance, start-beat mode decode and the per-beat view of the instruction state.
  always_comb begin
    accept    = resp.valid & resp_ready;
    start_acc = accept & resp.start_flag;
    if (resp.scalar)         start_mode = WB_SCALAR;
    else if (resp.whole_reg) start_mode = WB_PASS;
    else if (resp.mask)      start_mode = WB_MASK;
    else if (resp.narrow)    start_mode = WB_NARROW;
    else                     start_mode = WB_PASS;
    beat_mode = resp.start_flag ? start_mode : mode_q;
    live      = accept & (resp.start_flag | open_q);
    base_ptr  = resp.start_flag ? beat_addr : wr_ptr_q;
    cur_half  = resp.start_flag ? 1'b0 : half_q;
    cur_first = resp.start_flag ? 1'b1 : first_q;
    m_insert  = live & (beat_mode == WB_MASK);
  end

  valu_mask_accum u_mask (
    .clk      (clk),
    .rst      (rst),
    .clear    (start_acc),
    .insert   (m_insert),
    .end_flag (resp.end_flag),
    .sew      (resp.sew),
    .bits     (resp.data[7:0]),
    .emit     (m_emit),
    .word     (m_word),
    .be       (m_be),
    .pending  (m_pending)
  );

  // Next instruction state and the word (if any) this beat produces.
  always_comb begin
    mode_d    = mode_q;
    open_d    = open_q;
    half_d    = half_q;
    first_d   = first_q;
    wr_ptr_d  = wr_ptr_q;
    lo_dat_d  = lo_dat_q;
    lo_be_d   = lo_be_q;
    emit      = 1'b0;
    emit_beat = '0;
    sca_d     = 1'b0;
    err_d     = 1'b0;
    // A restart over a pending half-word or partial mask word loses data.
    if (start_acc && open_q &&
        ((mode_q == WB_NARROW && half_q) || (mode_q == WB_MASK && m_pending))) begin
      err_d = 1'b1;
    end
    if (accept && !resp.start_flag && !open_q) begin
      err_d = 1'b1;
    end
    if (live) begin
      mode_d   = beat_mode;
      open_d   = !resp.end_flag;
      half_d   = cur_half;
      first_d  = cur_first;
      wr_ptr_d = base_ptr;
      emit_beat.valid = 1'b1;
      case (beat_mode)
        WB_SCALAR: sca_d = 1'b1;
        WB_PASS: begin
          emit                 = 1'b1;
          emit_beat.addr       = beat_addr;
          emit_beat.data       = resp.data;
          emit_beat.be         = resp.be;
          emit_beat.start_flag = resp.start_flag;
          emit_beat.end_flag   = resp.end_flag;
        end
        WB_NARROW: begin
          emit_beat.addr       = base_ptr;
          emit_beat.start_flag = cur_first;
          emit_beat.end_flag   = resp.end_flag;
          if (!cur_half) begin
            if (resp.end_flag) begin
              emit           = 1'b1;
              emit_beat.data = {{NARROW_HALF{1'b0}}, resp.data[NARROW_HALF-1:0]};
              emit_beat.be   = {{HB{1'b0}}, resp.be[HB-1:0]};
              first_d        = 1'b0;
            end else begin
              lo_dat_d = resp.data[NARROW_HALF-1:0];
              lo_be_d  = resp.be[HB-1:0];
              half_d   = 1'b1;
            end
          end else begin
            emit           = 1'b1;
            emit_beat.data = {resp.data[NARROW_HALF-1:0], lo_dat_q};
            emit_beat.be   = {resp.be[HB-1:0], lo_be_q};
            wr_ptr_d       = base_ptr + 1'b1;
            half_d         = 1'b0;
            first_d        = 1'b0;
          end
        end
        WB_MASK: begin
          if (m_emit) begin
            emit                 = 1'b1;
            emit_beat.addr       = base_ptr;
            emit_beat.data       = m_word;
            emit_beat.be         = m_be;
            emit_beat.start_flag = cur_first;
            emit_beat.end_flag   = resp.end_flag;
            wr_ptr_d             = base_ptr + 1'b1;
            first_d              = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Instruction state, output register and single-cycle side-band pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q    <= WB_PASS;
      open_q    <= 1'b0;
      half_q    <= 1'b0;
      first_q   <= 1'b0;
      wr_ptr_q  <= '0;
      lo_dat_q  <= '0;
      lo_be_q   <= '0;
      wb        <= '0;
      sca_valid <= 1'b0;
      sca_data  <= '0;
      err       <= 1'b0;
    end else begin
      mode_q    <= mode_d;
      open_q    <= open_d;
      half_q    <= half_d;
      first_q   <= first_d;
      wr_ptr_q  <= wr_ptr_d;
      lo_dat_q  <= lo_dat_d;
      lo_be_q   <= lo_be_d;
      sca_valid <= sca_d;
      err       <= err_d;
      if (sca_d) sca_data <= resp.data;
      if (resp_ready) begin
        if (emit) wb <= emit_beat;
        else      wb.valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_valu_wb_packer.sv
// Scoreboard bench for valu_wb_packer: directed cases plus randomized instructions vs. a bitstream model.
// Latency: expectations queued at issue time; monitor pops at each wb transfer / sca pulse.
// Backpressure: wb_ready forced low or randomized; hold stability and resp_ready checked while stalled.
module tb_valu_wb_packer;
  import rvvLitePkg::*;

  logic        clk = 1'b0;
  logic        rst;
  valu_resp_t  resp;
  logic        resp_ready;
  dstream_t    wb;
  logic        wb_ready;
  logic        sca_valid;
  logic [63:0] sca_data;
  logic        err;

  valu_wb_packer dut (
    .clk(clk), .rst(rst), .resp(resp), .resp_ready(resp_ready), .wb(wb),
    .wb_ready(wb_ready), .sca_valid(sca_valid), .sca_data(sca_data), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] addr;
    logic [63:0] data;
    logic [7:0]  be;
    logic        sf;
    logic        ef;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] sca_q[$];
  int checks = 0, failures = 0, err_seen = 0, exp_err = 0;
  logic bp_force = 1'b0, bp_rand = 1'b0;
  bit last_pending = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic [11:0] a, input logic [63:0] d, input logic [7:0] be,
                          input logic sf, input logic ef);
    exp_t e;
    e.addr = a; e.data = d; e.be = be; e.sf = sf; e.ef = ef;
    exp_q.push_back(e);
  endtask

  function automatic valu_resp_t mk(input bit sf, input bit ef, input logic [4:0] a,
                                    input logic [6:0] o, input logic [63:0] d, input logic [7:0] be,
                                    input logic [1:0] sew, input bit sc, input bit mk_b, input bit nw);
    valu_resp_t t;
    t = '0;
    t.start_flag = sf; t.end_flag = ef; t.addr = a; t.off = o; t.data = d; t.be = be;
    t.sew = sew; t.scalar = sc; t.mask = mk_b; t.narrow = nw;
    return t;
  endfunction

  // Present one beat until accepted (bounded).
  task automatic send_beat(input valu_resp_t b);
    int waited = 0;
    @(negedge clk);
    resp = b;
    resp.valid = 1'b1;
    while (!resp_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!resp_ready) begin
      failures++;
      $display("FAIL accept_timeout: resp_ready stuck at %0b, required 1", resp_ready);
      resp.valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    resp.valid = 1'b0;
  endtask

  // Reference: treat each mode's payload as a stream and cut it into words.
  task automatic model(input valu_resp_t b[$], input int mode, input bit ended, output bit pending);
    logic [11:0] base;
    int k, nw, len, cnt;
    logic [63:0] w64;
    logic [31:0] hi;
    logic [3:0]  hib;
    bit bq[$];
    base = {b[0].addr, b[0].off};
    pending = 1'b0;
    k = b.size();
    case (mode)
      0: foreach (b[i]) push_exp({b[i].addr, b[i].off}, b[i].data, b[i].be, b[i].start_flag, b[i].end_flag);
      1: begin
        nw = ended ? (k + 1) / 2 : k / 2;
        for (int w = 0; w < nw; w++) begin
          hi = 32'h0; hib = 4'h0;
          if (2*w + 1 < k) begin
            hi = b[2*w+1].data[31:0];
            hib = b[2*w+1].be[3:0];
          end
          push_exp(12'(base + w), {hi, b[2*w].data[31:0]}, {hib, b[2*w].be[3:0]},
                   w == 0, ended && (w == nw - 1));
        end
        pending = !ended && (k % 2 == 1);
      end
      2: begin
        foreach (b[i]) for (int j = 0; j < (8 >> b[i].sew); j++) bq.push_back(b[i].data[j]);
        len = bq.size();
        nw = ended ? (len + 63) / 64 : len / 64;
        for (int w = 0; w < nw; w++) begin
          cnt = (len - 64*w > 64) ? 64 : len - 64*w;
          w64 = '0;
          for (int j = 0; j < cnt; j++) w64[j] = bq[64*w + j];
          push_exp(12'(base + w), w64, (cnt == 64) ? 8'hFF : 8'((1 << ((cnt + 7) / 8)) - 1),
                   w == 0, ended && (w == nw - 1));
        end
        pending = !ended && (len % 64 != 0);
      end
      default: foreach (b[i]) sca_q.push_back(b[i].data);
    endcase
  endtask

  task automatic run_instr(input int mode, input int len, input bit ended, input logic [1:0] sew);
    valu_resp_t b[$];
    valu_resp_t t;
    bit pend;
    logic [4:0] a;
    logic [6:0] o;
    a = 5'($urandom);
    o = 7'($urandom);
    for (int i = 0; i < len; i++) begin
      t = '0;
      t.start_flag = (i == 0);
      t.end_flag = ended && (i == len - 1);
      t.addr = a; t.off = o;
      if (mode == 0 && i > 0) begin t.addr = 5'($urandom); t.off = 7'($urandom); end
      t.sew = sew;
      t.data = {$urandom, $urandom};
      t.be = 8'($urandom);
      if (i == 0) begin
        case (mode)
          3: begin t.scalar = 1'b1; t.mask = 1'($urandom); t.narrow = 1'($urandom); end
          2: begin t.mask = 1'b1; t.narrow = 1'($urandom); end
          1: t.narrow = 1'b1;
          default: begin
            t.whole_reg = 1'($urandom);
            if (t.whole_reg) begin t.mask = 1'($urandom); t.narrow = 1'($urandom); end
          end
        endcase
      end else begin
        t.mask = 1'($urandom); t.narrow = 1'($urandom); t.scalar = 1'($urandom);
      end
      b.push_back(t);
    end
    if (last_pending) exp_err++;
    model(b, mode, ended, pend);
    last_pending = pend;
    foreach (b[i]) send_beat(b[i]);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || sca_q.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    chk({name, "_wb_left"}, 64'(exp_q.size()), 64'd0);
    chk({name, "_sca_left"}, 64'(sca_q.size()), 64'd0);
    exp_q.delete();
    sca_q.delete();
  endtask

  // wb_ready driver, updated just after each active edge.
  initial begin
    wb_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      wb_ready = bp_force ? 1'b0 : (bp_rand ? ($urandom_range(0, 3) != 0) : 1'b1);
    end
  end

  // Monitor: scoreboard pops, hold stability, scalar pulses, err count.
  initial begin : monitor
    dstream_t prev;
    logic stalled;
    exp_t e;
    stalled = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (stalled) begin
          checks++;
          if (wb !== prev) begin
            failures++;
            $display("FAIL wb_hold: got %h expected %h", wb, prev);
          end
        end
        if (wb.valid && !wb_ready) begin
          checks++;
          if (resp_ready !== 1'b0) begin
            failures++;
            $display("FAIL ready_stall: resp_ready=%0b required 0", resp_ready);
          end
        end
        if (wb.valid && wb_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL wb_unexpected: addr=%h data=%h be=%h, none required", wb.addr, wb.data, wb.be);
          end else begin
            e = exp_q.pop_front();
            if (wb.addr !== e.addr || wb.data !== e.data || wb.be !== e.be ||
                wb.start_flag !== e.sf || wb.end_flag !== e.ef) begin
              failures++;
              $display("FAIL wb_beat: got addr=%h data=%h be=%h s=%0b e=%0b required addr=%h data=%h be=%h s=%0b e=%0b",
                       wb.addr, wb.data, wb.be, wb.start_flag, wb.end_flag, e.addr, e.data, e.be, e.sf, e.ef);
            end
          end
        end
        if (sca_valid) begin
          checks++;
          if (sca_q.size() == 0) begin
            failures++;
            $display("FAIL sca_unexpected: data=%h, none required", sca_data);
          end else if (sca_data !== sca_q[0]) begin
            failures++;
            $display("FAIL sca_data: got %h required %h", sca_data, sca_q[0]);
            void'(sca_q.pop_front());
          end else begin
            void'(sca_q.pop_front());
          end
        end
        if (err) err_seen++;
        stalled = wb.valid && !wb_ready;
        prev = wb;
      end else begin
        stalled = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int len;
    logic [1:0] sew;
    resp = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_wb_valid", 64'(wb.valid), 64'd0);
    chk("rst_wb_zero", 64'(wb == '0), 64'd1);
    chk("rst_resp_ready", 64'(resp_ready), 64'd1);
    chk("rst_sca_valid", 64'(sca_valid), 64'd0);
    chk("rst_sca_data", sca_data, 64'd0);
    chk("rst_err", 64'(err), 64'd0);

    // PASS single beat
    push_exp(12'h283, 64'h1122334455667788, 8'hFF, 1'b1, 1'b1);
    send_beat(mk(1, 1, 5'd5, 7'd3, 64'h1122334455667788, 8'hFF, 2'd0, 0, 0, 0));
    // NARROW three halves
    push_exp(12'h100, 64'hBBBBBBBBAAAAAAAA, 8'hFF, 1'b1, 1'b0);
    push_exp(12'h101, 64'h00000000CCCCCCCC, 8'h0F, 1'b0, 1'b1);
    send_beat(mk(1, 0, 5'd2, 7'd0, 64'hDEAD0001AAAAAAAA, 8'hFF, 2'd0, 0, 0, 1));
    send_beat(mk(0, 0, 5'd2, 7'd0, 64'hDEAD0002BBBBBBBB, 8'hFF, 2'd0, 0, 0, 1));
    send_beat(mk(0, 1, 5'd2, 7'd0, 64'hDEAD0003CCCCCCCC, 8'hFF, 2'd0, 0, 0, 1));
    // MASK sew=0, nine bytes
    push_exp(12'h080, 64'h0807060504030201, 8'hFF, 1'b1, 1'b0);
    push_exp(12'h081, 64'h0000000000000009, 8'h01, 1'b0, 1'b1);
    for (int i = 1; i <= 9; i++)
      send_beat(mk(i == 1, i == 9, 5'd1, 7'd0, 64'(i), 8'hFF, 2'd0, 0, 1, 0));
    drain("directed");

    // Backpressure: hold wb_ready low while a beat is presented
    bp_force = 1'b1;
    @(negedge clk);
    fork
      for (int i = 0; i < 4; i++) run_instr(0, 1, 1'b1, 2'd0);
      begin
        repeat (4) @(negedge clk);
        chk("bp_stalled", 64'(wb.valid && !resp_ready), 64'd1);
        bp_force = 1'b0;
      end
    join
    drain("bp");

    // SCALAR
    sca_q.push_back(64'h7F);
    send_beat(mk(1, 1, 5'd7, 7'd9, 64'h7F, 8'hFF, 2'd0, 1, 0, 0));
    drain("scalar");
    chk("err_none_yet", 64'(err_seen), 64'(exp_err));

    // Restart over a partial mask word: partial word dropped, err once
    for (int i = 0; i < 3; i++)
      send_beat(mk(i == 0, 0, 5'd3, 7'd0, 64'hFF, 8'hFF, 2'd0, 0, 1, 0));
    push_exp(12'h201, 64'hCAFEF00D12345678, 8'h3C, 1'b1, 1'b1);
    exp_err++;
    send_beat(mk(1, 1, 5'd4, 7'd1, 64'hCAFEF00D12345678, 8'h3C, 2'd0, 0, 0, 0));
    drain("restart");
    chk("err_restart", 64'(err_seen), 64'(exp_err));

    // Continuation beat while idle: dropped, err once
    exp_err++;
    send_beat(mk(0, 0, 5'd6, 7'd2, 64'h55, 8'hFF, 2'd0, 0, 0, 0));
    drain("idle");
    chk("err_idle", 64'(err_seen), 64'(exp_err));

    // Reset mid NARROW: half word lost, no err on the next start
    send_beat(mk(1, 0, 5'd8, 7'd0, 64'h11112222, 8'hFF, 2'd0, 0, 0, 1));
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_wb_valid", 64'(wb.valid), 64'd0);
    push_exp(12'h3C5, 64'h0123456789ABCDEF, 8'h81, 1'b1, 1'b1);
    send_beat(mk(1, 1, 5'd7, 7'd69, 64'h0123456789ABCDEF, 8'h81, 2'd0, 0, 0, 0));
    drain("rst_mid");
    chk("err_rst_mid", 64'(err_seen), 64'(exp_err));

    // Randomized instructions with random backpressure and occasional aborts
    bp_rand = 1'b1;
    last_pending = 1'b0;
    for (int k = 0; k < 60; k++) begin
      int mode;
      mode = $urandom_range(0, 3);
      sew = 2'($urandom_range(0, 3));
      len = (mode == 2) ? $urandom_range(1, 24) : $urandom_range(1, 7);
      run_instr(mode, len, ($urandom_range(0, 6) != 0) || (k == 59), sew);
    end
    drain("random");
    bp_rand = 1'b0;
    chk("err_random", 64'(err_seen), 64'(exp_err));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
